// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the scan controller and whatever drives it:
// scan controls in, display selects and decoder nibble out.
interface display_scan_ctrl_if;
    logic        run;
    logic [3:0]  digit_mask;
    logic [15:0] data_in;
    logic [3:0]  anode_n;
    logic [3:0]  nibble;
    logic [1:0]  digit_idx;
    logic        frame_done;

    modport master (
        output run, digit_mask, data_in,
        input  anode_n, nibble, digit_idx, frame_done
    );

    modport slave (
        input  run, digit_mask, data_in,
        output anode_n, nibble, digit_idx, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan scheduler: each enabled digit gets a
// blanked dead-time slot followed by a lit slot, with a pulse on every frame wrap.
module display_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    display_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [1:0]       r_idx, w_idx;
    logic [3:0]       r_nibble, w_nibble;
    logic [3:0]       r_anode, w_anode;
    logic             r_frameDone, w_frameDone;
    logic [1:0]       w_startIdx, w_slotIdx;

    // Round-robin search starting just after cur; cur itself is tried last.
    function automatic logic [1:0] nextIdx(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] result;
        logic [1:0] cand;
        logic       found;
        result = cur;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = cur + 2'(k);
            if (!found && mask[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic logic [3:0] selNibble(input logic [15:0] data, input logic [1:0] i);
        logic [3:0] result;
        case (i)
            2'd0:    result = data[3:0];
            2'd1:    result = data[7:4];
            2'd2:    result = data[11:8];
            default: result = data[15:12];
        endcase
        return result;
    endfunction

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_nibble    = r_nibble;
        w_anode     = 4'b1111;
        w_frameDone = 1'b0;
        // Searching after digit 3 yields the lowest set bit of the mask.
        w_startIdx  = nextIdx(bus.digit_mask, 2'd3);
        w_slotIdx   = nextIdx(bus.digit_mask, r_idx);

        case (r_state)
            IDLE: begin
                if (bus.run && bus.digit_mask != 4'b0000) begin
                    w_state  = BLANK;
                    w_idx    = w_startIdx;
                    w_nibble = selNibble(bus.data_in, w_startIdx);
                    w_cnt    = '0;
                end
            end
            BLANK: begin
                if (!bus.run) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end else if (r_cnt == BLANK_LAST) begin
                    w_state = SHOW;
                    w_cnt   = '0;
                    w_anode = ~(4'b0001 << r_idx);
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (!bus.run) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end else if (r_cnt == SHOW_LAST) begin
                    w_cnt = '0;
                    if (bus.digit_mask == 4'b0000) begin
                        w_state = IDLE;
                    end else begin
                        w_state     = BLANK;
                        w_idx       = w_slotIdx;
                        w_nibble    = selNibble(bus.data_in, w_slotIdx);
                        // Not moving forward means the scan went round past digit 3.
                        w_frameDone = (w_slotIdx <= r_idx);
                    end
                end else begin
                    w_cnt   = r_cnt + 1'b1;
                    w_anode = r_anode;
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_nibble    <= 4'h0;
            r_anode     <= 4'b1111;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_nibble    <= w_nibble;
            r_anode     <= w_anode;
            r_frameDone <= w_frameDone;
        end
    end

    assign bus.anode_n    = r_anode;
    assign bus.nibble     = r_nibble;
    assign bus.digit_idx  = r_idx;
    assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected per-cycle outputs are queued
// slot by slot as stimulus is applied and compared on the falling edge.
module tb_display_scan_ctrl;

    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 2;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] nib;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;
    exp_t expQ[$];

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic [3:0] mask, input logic [15:0] data);
        bus.run        = run;
        bus.digit_mask = mask;
        bus.data_in    = data;
    endtask

    task automatic pushIdle(input int n, input logic [3:0] nib, input logic [1:0] idx);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{anode: 4'b1111, nib: nib, idx: idx, fd: 1'b0};
            expQ.push_back(e);
        end
    endtask

    // A slot seen from outside: blank cycles (pulse on the first if wrapping), then lit cycles.
    task automatic pushSlot(input logic [1:0] idx, input logic [3:0] nib, input logic fd,
                            input int blankN, input int showN);
        exp_t       e;
        logic [3:0] lit;
        lit = 4'b1111;
        lit[idx] = 1'b0;
        for (int i = 0; i < blankN; i++) begin
            e = '{anode: 4'b1111, nib: nib, idx: idx, fd: (i == 0) ? fd : 1'b0};
            expQ.push_back(e);
        end
        for (int i = 0; i < showN; i++) begin
            e = '{anode: lit, nib: nib, idx: idx, fd: 1'b0};
            expQ.push_back(e);
        end
    endtask

    task automatic drainQueue();
        exp_t e;
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            checkOutput("anode_n",    32'(bus.anode_n),    32'(e.anode));
            checkOutput("nibble",     32'(bus.nibble),     32'(e.nib));
            checkOutput("digit_idx",  32'(bus.digit_idx),  32'(e.idx));
            checkOutput("frame_done", 32'(bus.frame_done), 32'(e.fd));
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 4'b0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Idle after reset with run low
        reset = 1'b0;
        pushIdle(20, 4'h0, 2'd0);
        drainQueue();

        // Full mask: digits 0..3, wrap pulse on returning to digit 0
        applyStimulus(1'b1, 4'b1111, 16'h4321);
        pushSlot(2'd0, 4'h1, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd1, 4'h2, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd2, 4'h3, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd3, 4'h4, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd0, 4'h1, 1'b1, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd1, 4'h2, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd2, 4'h3, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd3, 4'h4, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd0, 4'h1, 1'b1, BLANK_CYCLES, CLK_DIV);
        drainQueue();

        // Sparse mask 1010 taken at the end of the digit 0 slot
        applyStimulus(1'b1, 4'b1010, 16'h4321);
        pushSlot(2'd1, 4'h2, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd3, 4'h4, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd1, 4'h2, 1'b1, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd3, 4'h4, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd1, 4'h2, 1'b1, BLANK_CYCLES, CLK_DIV);
        drainQueue();

        // Single digit: every slot is a wrap except the first move onto it
        applyStimulus(1'b1, 4'b0100, 16'h4321);
        pushSlot(2'd2, 4'h3, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd2, 4'h3, 1'b1, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd2, 4'h3, 1'b1, BLANK_CYCLES, CLK_DIV);
        drainQueue();

        // Empty mask at slot end drops to idle and stays there with run high
        applyStimulus(1'b1, 4'b0000, 16'h4321);
        pushIdle(8, 4'h3, 2'd2);
        drainQueue();

        // Mask and data changed in the middle of digit 1's lit time
        applyStimulus(1'b1, 4'b1111, 16'h4321);
        pushSlot(2'd0, 4'h1, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd1, 4'h2, 1'b0, BLANK_CYCLES, 2);
        drainQueue();
        applyStimulus(1'b1, 4'b0001, 16'h8765);
        pushSlot(2'd1, 4'h2, 1'b0, 0, CLK_DIV - 2);
        pushSlot(2'd0, 4'h5, 1'b1, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd0, 4'h5, 1'b1, BLANK_CYCLES, 2);
        drainQueue();

        // Run dropped while lit, then restarted on a new mask
        applyStimulus(1'b0, 4'b0001, 16'h8765);
        pushIdle(3, 4'h5, 2'd0);
        drainQueue();
        applyStimulus(1'b1, 4'b0110, 16'h8765);
        pushSlot(2'd1, 4'h6, 1'b0, BLANK_CYCLES, CLK_DIV);
        pushSlot(2'd2, 4'h7, 1'b0, BLANK_CYCLES, 2);
        drainQueue();

        // Asynchronous reset between clock edges while digit 2 is lit
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_anode_n",    32'(bus.anode_n),    32'h0000000f);
        checkOutput("async_nibble",     32'(bus.nibble),     32'h0);
        checkOutput("async_digit_idx",  32'(bus.digit_idx),  32'h0);
        checkOutput("async_frame_done", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0110, 16'h8765);
        reset = 1'b0;
        pushIdle(5, 4'h0, 2'd0);
        drainQueue();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
